spike_piso_tx: RTL and testbench
================================

SPIKE_PISO_TX -- requirements
Module: spike_piso_tx

Interface
REQ-001 The module SHALL have parameter N_OUT, default 10, which is the number of output-neuron spike lines.
REQ-002 The module SHALL have parameter CHUNK, default 2, which is the serial chunk width; legal values are 1, 2, 4 and 8.
REQ-003 The module SHALL have parameter CNT_BITS, default 8, which is the per-neuron spike counter width and is used only when SPIKE_COUNT_EN is defined.
REQ-004 The module SHALL have port clk, input, 1 bit: the clock.
REQ-005 The module SHALL have port reset, input, 1 bit: the reset, synchronous, active-high.
REQ-006 The module SHALL have port spikes_i, input, N_OUT bits: the spike vector from the final layer.
REQ-007 The module SHALL have port accumulate_i, input, 1 bit: add spikes_i into the counters (count mode only).
REQ-008 The module SHALL have port capture_i, input, 1 bit: snapshot and start a frame.
REQ-009 The module SHALL have port data_o, output, CHUNK bits: the current serial chunk.
REQ-010 The module SHALL have port valid_o, output, 1 bit: data_o is valid.
REQ-011 The module SHALL have port ready_i, input, 1 bit: the consumer accepts data_o.
REQ-012 The module SHALL have port sof_o, output, 1 bit: the current chunk is the first chunk of the frame.
REQ-013 The module SHALL have port eof_o, output, 1 bit: the current chunk is the last chunk of the frame.
REQ-014 The module SHALL have port busy_o, output, 1 bit: a frame is in progress.
REQ-015 The module SHALL have port overrun_o, output, 1 bit: sticky flag indicating a capture was dropped.

Function
REQ-016 The module SHALL implement a two-state FSM with states IDLE and SEND, where busy_o is 1 exactly when the state is SEND.
REQ-017 In IDLE, capture_i=1 SHALL load the frame shift register and enter SEND on the next cycle, so valid_o=1 with chunk 0 appears one cycle after capture_i.
REQ-018 The frame payload SHALL be spikes_i sampled on the capture cycle (plain mode), or the counter vector (count mode), with zero-padding in the MSBs up to a multiple of CHUNK.
REQ-019 Serialization SHALL be LSB-first, with data_o equal to bits [CHUNK-1:0] of the shift register.
REQ-020 A handshake SHALL occur when valid_o and ready_i are both 1 in the same cycle; on a handshake the register shifts right by CHUNK and the chunk counter decrements.
REQ-021 While valid_o=1 and ready_i=0, data_o, sof_o and eof_o SHALL hold stable.
REQ-022 The frame length SHALL be FRAME_CHUNKS = ceil(payload_bits/CHUNK); sof_o SHALL be valid_o AND (chunk index = 0), and eof_o SHALL be valid_o AND (chunk index = FRAME_CHUNKS-1).
REQ-023 A handshake on the last chunk SHALL return the FSM to IDLE.
REQ-024 If capture_i=1 in the same cycle as the last-chunk handshake, the module SHALL reload and stay in SEND with no bubble cycle.
REQ-025 A capture_i=1 in SEND, other than on the last-chunk handshake cycle, SHALL be ignored and SHALL set overrun_o, which stays set until reset.
REQ-026 valid_o SHALL be 0 whenever the state is IDLE.

Reset
REQ-027 On reset=1 the module SHALL enter IDLE within one clk edge, and the shift register, chunk counter, spike counters and overrun_o SHALL go to 0.
REQ-028 During and after reset, data_o, valid_o, sof_o, eof_o and busy_o SHALL be 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no eof_o emitted.
REQ-030 Reset SHALL take priority over capture_i and accumulate_i in the same cycle.

Configuration
REQ-031 The macro SPIKE_COUNT_EN, when defined, SHALL compile in N_OUT counters of CNT_BITS each.
REQ-032 In count mode, on accumulate_i=1 each counter whose spikes_i bit is 1 SHALL increment by 1, saturating at 2^CNT_BITS-1.
REQ-033 In count mode the payload SHALL be N_OUT*CNT_BITS bits, with counter k occupying bits [k*CNT_BITS +: CNT_BITS].
REQ-034 On an accepted capture in count mode, the snapshot SHALL include the same cycle's accumulate increment, and the counters SHALL clear to 0 on the next cycle.
REQ-035 On an ignored capture in count mode, the counters SHALL not clear.
REQ-036 Counting SHALL continue while the state is SEND.
REQ-037 When SPIKE_COUNT_EN is not defined, no counters SHALL exist, accumulate_i SHALL be ignored, and the payload SHALL be N_OUT bits.

Structure
REQ-038 Package spike_tx_pkg SHALL hold the state enum (IDLE, SEND) and the default constants N_OUT, CHUNK and CNT_BITS.
REQ-039 Package spike_tx_pkg SHALL hold a constant function that computes FRAME_CHUNKS.
REQ-040 The design SHALL contain one sub-module, sat_counter (a CNT_BITS saturating counter with inc and clr inputs), instantiated N_OUT times under SPIKE_COUNT_EN.

Verification
REQ-041 Plain mode, ready_i tied to 1: capture_i with spikes_i=10'h2CD SHALL produce data_o 01,11,00,11,10 on consecutive cycles starting the cycle after capture, with sof_o on chunk 0, eof_o on chunk 4, then valid_o=0.
REQ-042 Backpressure: the same frame with ready_i toggling 1,0,0,1,… SHALL leave data_o unchanged during the 0 cycles and emit all 5 chunks exactly once.
REQ-043 Back-to-back: capture 10'h3FF, then capture 10'h001 on the last-chunk handshake SHALL give chunk 0 = 01 on the next cycle with no valid_o gap; overrun_o SHALL remain 0.
REQ-044 Overrun: capture_i during chunk 2 of a frame SHALL leave the frame unaltered and set overrun_o=1, which persists until reset.
REQ-045 Count mode: 3 accumulate cycles with spikes_i=10'h001 followed by capture SHALL produce 40 chunks, the first four being 11,00,00,00 and all others 00; a following capture SHALL send all zeros.
REQ-046 Count-mode saturation and reset: 300 accumulate cycles with bit 1 set SHALL snapshot counter 1 as 8'hFF; reset asserted at chunk 5 SHALL return busy_o=0 and valid_o=0 on the next cycle.

Source files
------------

// File: rtl/spike_tx_pkg.sv
// Shared types and defaults for the spike PISO transmitter.
// The optional counter mode is selected by the SPIKE_COUNT_EN macro.
package spike_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DEFAULT_N_OUT    = 10;
  localparam int DEFAULT_CHUNK    = 2;
  localparam int DEFAULT_CNT_BITS = 8;

  // Payload is zero-padded in the MSBs up to a whole number of chunks.
  function automatic int frame_chunks(input int payload_bits, input int chunk);
    return (payload_bits + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating spike counter; snap_o is the value including this cycle's increment.
module sat_counter #(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                clr,
  output logic [CNT_BITS-1:0] snap_o
);

  logic [CNT_BITS-1:0] count_q;

  always_comb begin
    snap_o = count_q;
    if (inc && (count_q != {CNT_BITS{1'b1}})) begin
      snap_o = count_q + 1'b1;
    end
  end

  // Clear wins over increment: that increment already went into the snapshot.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else begin
      count_q <= snap_o;
    end
  end

endmodule

// File: rtl/spike_piso_tx.sv
// Parallel-in serial-out framer for output-layer spikes with valid/ready handshake.
// Define SPIKE_COUNT_EN to send per-neuron spike counts instead of the raw spike vector.
module spike_piso_tx
  import spike_tx_pkg::*;
#(
  parameter int N_OUT    = DEFAULT_N_OUT,
  parameter int CHUNK    = DEFAULT_CHUNK,
  parameter int CNT_BITS = DEFAULT_CNT_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_OUT-1:0] spikes_i,
  input  logic             accumulate_i,
  input  logic             capture_i,
  output logic [CHUNK-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o,
  output logic             overrun_o
);

`ifdef SPIKE_COUNT_EN
  localparam int PAYLOAD_W = N_OUT * CNT_BITS;
`else
  localparam int PAYLOAD_W = N_OUT;
`endif
  localparam int FRAME_CHUNKS = frame_chunks(PAYLOAD_W, CHUNK);
  localparam int SR_W         = FRAME_CHUNKS * CHUNK;
  localparam int RW           = $clog2(FRAME_CHUNKS + 1);
  localparam logic [RW-1:0] RELOAD = RW'(FRAME_CHUNKS);
  localparam logic [RW-1:0] LAST   = RW'(1);

  state_t               state_q, state_d;
  logic [SR_W-1:0]      shift_q;
  logic [RW-1:0]        rem_q;
  logic [PAYLOAD_W-1:0] payload;
  logic                 handshake, last_hs, load;
  logic                 overrun_q;

  assign handshake = (state_q == SEND) && ready_i;
  assign last_hs   = handshake && (rem_q == LAST);
  assign load      = capture_i && ((state_q == IDLE) || last_hs);

`ifdef SPIKE_COUNT_EN
  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    sat_counter #(
      .CNT_BITS(CNT_BITS)
    ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (accumulate_i && spikes_i[k]),
      .clr    (load),
      .snap_o (payload[k*CNT_BITS +: CNT_BITS])
    );
  end
`else
  logic unused_cfg;
  assign payload    = spikes_i;
  assign unused_cfg = accumulate_i ^ (CNT_BITS == 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (capture_i) state_d = SEND;
      SEND: if (last_hs && !capture_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A reload on the final handshake replaces the shift, giving back-to-back frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      rem_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (load) begin
        shift_q <= SR_W'(payload);
        rem_q   <= RELOAD;
      end else if (handshake) begin
        shift_q <= shift_q >> CHUNK;
        rem_q   <= rem_q - 1'b1;
      end
      if (capture_i && (state_q == SEND) && !last_hs) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign valid_o   = (state_q == SEND) && !reset;
  assign busy_o    = valid_o;
  assign data_o    = reset ? '0 : shift_q[CHUNK-1:0];
  assign sof_o     = valid_o && (rem_q == RELOAD);
  assign eof_o     = valid_o && (rem_q == LAST);
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_spike_piso_tx.sv
// Directed bench for spike_piso_tx; count-mode vectors run when SPIKE_COUNT_EN is defined.
module tb_spike_piso_tx;

  localparam int N_OUT    = 10;
  localparam int CHUNK    = 2;
  localparam int CNT_BITS = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_OUT-1:0] spikes_i;
  logic             accumulate_i;
  logic             capture_i;
  logic             ready_i;
  logic [CHUNK-1:0] data_o;
  logic             valid_o, sof_o, eof_o, busy_o, overrun_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spike_piso_tx #(
    .N_OUT    (N_OUT),
    .CHUNK    (CHUNK),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .spikes_i     (spikes_i),
    .accumulate_i (accumulate_i),
    .capture_i    (capture_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .sof_o        (sof_o),
    .eof_o        (eof_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [N_OUT-1:0] s);
    spikes_i  = s;
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
  endtask

  // Walk a whole frame with ready held high; optionally pulse capture on one chunk.
  task automatic drain(input string tag, input logic [511:0] frame, input int nch,
                       input int ovr_chunk);
    logic [511:0] sh;
    ready_i = 1'b1;
    for (int i = 0; i < nch; i++) begin
      sh = frame >> (i * CHUNK);
      check($sformatf("%s valid c%0d", tag, i), 64'(valid_o), 64'd1);
      check($sformatf("%s data c%0d", tag, i), 64'(data_o), 64'(sh[CHUNK-1:0]));
      check($sformatf("%s sof c%0d", tag, i), 64'(sof_o), 64'(i == 0));
      check($sformatf("%s eof c%0d", tag, i), 64'(eof_o), 64'(i == nch - 1));
      capture_i = (i == ovr_chunk);
      tick();
    end
    capture_i = 1'b0;
    check({tag, " valid after"}, 64'(valid_o), 64'd0);
    check({tag, " busy after"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    logic [1:0] exp_2cd [5];
    int idx;
    int cyc;
    exp_2cd = '{2'b01, 2'b11, 2'b00, 2'b11, 2'b10};

    reset = 1'b1; spikes_i = '0; accumulate_i = 1'b0; capture_i = 1'b0; ready_i = 1'b0;
    tick(); tick();
    check("rst valid", 64'(valid_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst data", 64'(data_o), 64'd0);
    check("rst sof", 64'(sof_o), 64'd0);
    check("rst eof", 64'(eof_o), 64'd0);
    check("rst overrun", 64'(overrun_o), 64'd0);
    reset = 1'b0;
    tick();
    check("idle valid", 64'(valid_o), 64'd0);

    // Basic frame, ready tied high
    ready_i = 1'b1;
    capture(10'h2CD);
    drain("basic", 512'h2CD, 5, -1);

    // Backpressure: ready pattern 1,0,0,1,0,0,...
    capture(10'h2CD);
    idx = 0;
    cyc = 0;
    while (idx < 5 && cyc < 40) begin
      ready_i = (cyc % 3 == 0);
      check($sformatf("bp data cyc%0d", cyc), 64'(data_o), 64'(exp_2cd[idx]));
      check($sformatf("bp sof cyc%0d", cyc), 64'(sof_o), 64'(idx == 0));
      check($sformatf("bp eof cyc%0d", cyc), 64'(eof_o), 64'(idx == 4));
      tick();
      if (ready_i) idx++;
      cyc++;
    end
    check("bp chunks sent", 64'(idx), 64'd5);
    check("bp cycles", 64'(cyc), 64'd13);
    check("bp valid after", 64'(valid_o), 64'd0);

    // Back-to-back reload on the last handshake
    ready_i = 1'b1;
    capture(10'h3FF);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b data c%0d", i), 64'(data_o), 64'd3);
      tick();
    end
    check("b2b eof c4", 64'(eof_o), 64'd1);
    check("b2b data c4", 64'(data_o), 64'd3);
    capture(10'h001);
    drain("b2b second", 512'h001, 5, -1);
    check("b2b overrun", 64'(overrun_o), 64'd0);

    // Overrun: capture mid-frame is ignored and sticks
    capture(10'h2CD);
    drain("ovr", 512'h2CD, 5, 2);
    check("ovr flag", 64'(overrun_o), 64'd1);
    tick(); tick();
    check("ovr sticky", 64'(overrun_o), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ovr cleared", 64'(overrun_o), 64'd0);

    // Reset mid-frame aborts with no eof
    capture(10'h2CD);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("abort valid", 64'(valid_o), 64'd0);
    check("abort busy", 64'(busy_o), 64'd0);
    check("abort eof", 64'(eof_o), 64'd0);
    reset = 1'b0;
    tick();
    check("abort idle", 64'(valid_o), 64'd0);

`ifdef SPIKE_COUNT_EN
    // Snapshot includes the capture cycle's increment: 2 + 1 = 3
    spikes_i = 10'h001;
    accumulate_i = 1'b1;
    tick(); tick();
    capture_i = 1'b1;
    tick();
    capture_i = 1'b0;
    accumulate_i = 1'b0;
    drain("cnt3", 512'h3, 40, -1);
    capture(10'h000);
    drain("cnt clr", 512'h0, 40, -1);

    // Saturation of counter 1, then reset at chunk 5
    spikes_i = 10'h002;
    accumulate_i = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    accumulate_i = 1'b0;
    capture(10'h000);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("sat data c%0d", i), 64'(data_o), (i >= 4) ? 64'd3 : 64'd0);
      tick();
    end
    check("sat data c5", 64'(data_o), 64'd3);
    reset = 1'b1;
    tick();
    check("sat rst valid", 64'(valid_o), 64'd0);
    check("sat rst busy", 64'(busy_o), 64'd0);
    reset = 1'b0;
    tick();
`else
    // accumulate_i has no effect in plain mode
    spikes_i = 10'h3FF;
    accumulate_i = 1'b1;
    tick(); tick(); tick();
    accumulate_i = 1'b0;
    check("plain acc idle", 64'(valid_o), 64'd0);
    capture(10'h000);
    drain("plain acc", 512'h0, 5, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
